pipe_hazard_ctrl: RTL and testbench

- Decode-side control for the decode/execute pipeline register. It produces the per-operand forwarding selects that the register captures, and the stall, bubble and flush controls that gate it.
- It consumes the execute- and memory-stage outputs of the pipeline registers: destination register, write/load flags and branch flags. From these it detects load-use hazards and taken branches, and drives the PC redirect.
- It keeps a small squash/stall state machine and saturating performance counters.

---
 rtl/pipe_hazard_ctrl.sv | 120 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Decode-side hazard control: operand forwarding selects, load-use stall,
// taken-branch redirect/flush, and saturating stall/flush event counters.
module pipe_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [4:0]       drs,
    input  logic [4:0]       drt,
    input  logic             duse_rs,
    input  logic             duse_rt,
    input  logic             duse_st,
    input  logic             ewreg,
    input  logic             em2reg,
    input  logic [4:0]       ern,
    input  logic             mwreg,
    input  logic             mm2reg,
    input  logic [4:0]       mrn,
    input  logic             ej,
    input  logic             ebeq,
    input  logic             ebne,
    input  logic             ezero,
    input  logic [31:0]      ebpc,
    output logic [1:0]       dadepen,
    output logic [1:0]       dbdepen,
    output logic [1:0]       dsdepen,
    output logic             wpcir,
    output logic             dbubble,
    output logic             fflush,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_LSTALL = 2'd1,
        ST_SQUASH = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Operand slots: 0 = operand a (rs), 1 = operand b (rt), 2 = store data (rt).
    logic [2:0][4:0]  w_src;
    logic [2:0]       w_use;
    logic [2:0][1:0]  w_sel;
    logic [2:0]       w_lu_hit;
    logic             w_load_use;
    logic             w_btaken;

    assign w_src = {drt, drt, drs};
    assign w_use = {duse_st, duse_rt, duse_rs};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_operand
            logic w_ex_hit;
            logic w_mem_hit;
            assign w_ex_hit  = ewreg && !em2reg && (ern != 5'd0) && (ern == w_src[gi]);
            assign w_mem_hit = mwreg && (mrn != 5'd0) && (mrn == w_src[gi]);
            // Memory-stage loads select the load data path (11), ALU results 10.
            assign w_sel[gi] = !w_use[gi] ? 2'b00 :
                               w_ex_hit   ? 2'b01 :
                               w_mem_hit  ? {1'b1, mm2reg} : 2'b00;
            assign w_lu_hit[gi] = w_use[gi] && ewreg && em2reg &&
                                  (ern != 5'd0) && (ern == w_src[gi]);
        end
    endgenerate

    assign w_load_use = |w_lu_hit;
    assign w_btaken   = ej | (ebeq & ezero) | (ebne & ~ezero);

    assign dadepen = w_sel[0];
    assign dbdepen = w_sel[1];
    assign dsdepen = w_sel[2];

    // A taken branch squashes decode, so it overrides any load-use stall.
    assign redirect    = w_btaken;
    assign redirect_pc = w_btaken ? ebpc : 32'h0;
    assign fflush      = w_btaken;
    assign dbubble     = w_btaken | w_load_use;
    assign wpcir       = w_btaken | ~w_load_use;

    assign w_state = clr ? ST_RUN : r_state;

    always_comb begin
        w_state_next = ST_RUN;
        case (w_state)
            ST_RUN, ST_LSTALL, ST_SQUASH: begin
                if (w_btaken)        w_state_next = ST_SQUASH;
                else if (w_load_use) w_state_next = ST_LSTALL;
                else                 w_state_next = ST_RUN;
            end
            default: w_state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state     <= ST_RUN;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_btaken) begin
                if (r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + 1'b1;
            end else if (w_load_use) begin
                if (r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a 16-bit and a 2-bit counter instance
// share stimulus; expected outputs are queued at drive time and checked at negedge.
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic [4:0]  drs;
        logic [4:0]  drt;
        logic        duse_rs;
        logic        duse_rt;
        logic        duse_st;
        logic        ewreg;
        logic        em2reg;
        logic [4:0]  ern;
        logic        mwreg;
        logic        mm2reg;
        logic [4:0]  mrn;
        logic        ej;
        logic        ebeq;
        logic        ebne;
        logic        ezero;
        logic [31:0] ebpc;
    } txn_t;

    typedef struct packed {
        logic [1:0]  dadepen;
        logic [1:0]  dbdepen;
        logic [1:0]  dsdepen;
        logic        wpcir;
        logic        dbubble;
        logic        fflush;
        logic        redirect;
        logic [31:0] redirect_pc;
        logic [15:0] stall_cnt;
        logic [15:0] flush_cnt;
        logic [1:0]  stall_s;
        logic [1:0]  flush_s;
    } exp_t;

    logic clk = 1'b0;
    logic clr;
    txn_t t_in;
    logic [1:0]  dadepen, dbdepen, dsdepen, dadepen_s, dbdepen_s, dsdepen_s;
    logic        wpcir, dbubble, fflush, redirect;
    logic        wpcir_s, dbubble_s, fflush_s, redirect_s;
    logic [31:0] redirect_pc, redirect_pc_s;
    logic [15:0] stall_cnt, flush_cnt;
    logic [1:0]  stall_cnt_s, flush_cnt_s;

    int n_checks = 0;
    int n_pass   = 0;
    exp_t exp_q[$];

    // Model counters (value currently held by the DUT registers)
    logic [15:0] m_stall, m_flush;
    logic [1:0]  m_stall_s, m_flush_s;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .clr(clr), .drs(t_in.drs), .drt(t_in.drt),
        .duse_rs(t_in.duse_rs), .duse_rt(t_in.duse_rt), .duse_st(t_in.duse_st),
        .ewreg(t_in.ewreg), .em2reg(t_in.em2reg), .ern(t_in.ern),
        .mwreg(t_in.mwreg), .mm2reg(t_in.mm2reg), .mrn(t_in.mrn),
        .ej(t_in.ej), .ebeq(t_in.ebeq), .ebne(t_in.ebne), .ezero(t_in.ezero),
        .ebpc(t_in.ebpc), .dadepen(dadepen), .dbdepen(dbdepen), .dsdepen(dsdepen),
        .wpcir(wpcir), .dbubble(dbubble), .fflush(fflush), .redirect(redirect),
        .redirect_pc(redirect_pc), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_hazard_ctrl #(.CNT_W(2)) dut_s (
        .clk(clk), .clr(clr), .drs(t_in.drs), .drt(t_in.drt),
        .duse_rs(t_in.duse_rs), .duse_rt(t_in.duse_rt), .duse_st(t_in.duse_st),
        .ewreg(t_in.ewreg), .em2reg(t_in.em2reg), .ern(t_in.ern),
        .mwreg(t_in.mwreg), .mm2reg(t_in.mm2reg), .mrn(t_in.mrn),
        .ej(t_in.ej), .ebeq(t_in.ebeq), .ebne(t_in.ebne), .ezero(t_in.ezero),
        .ebpc(t_in.ebpc), .dadepen(dadepen_s), .dbdepen(dbdepen_s), .dsdepen(dsdepen_s),
        .wpcir(wpcir_s), .dbubble(dbubble_s), .fflush(fflush_s), .redirect(redirect_s),
        .redirect_pc(redirect_pc_s), .stall_cnt(stall_cnt_s), .flush_cnt(flush_cnt_s)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    endtask

    function automatic logic [1:0] ref_sel(input txn_t t, input logic use_f, input logic [4:0] r);
        if (!use_f) return 2'b00;
        if (t.ewreg && !t.em2reg && t.ern != 0 && t.ern == r) return 2'b01;
        if (t.mwreg && t.mrn != 0 && t.mrn == r) return t.mm2reg ? 2'b11 : 2'b10;
        return 2'b00;
    endfunction

    function automatic logic ref_lu(input txn_t t);
        if (!(t.ewreg && t.em2reg && t.ern != 0)) return 1'b0;
        return (t.duse_rs && t.drs == t.ern) || ((t.duse_rt || t.duse_st) && t.drt == t.ern);
    endfunction

    function automatic logic ref_bt(input txn_t t);
        return t.ej || (t.ebeq && t.ezero) || (t.ebne && !t.ezero);
    endfunction

    function automatic exp_t ref_out(input txn_t t);
        exp_t e;
        logic bt, lu;
        bt = ref_bt(t);
        lu = ref_lu(t);
        e.dadepen     = ref_sel(t, t.duse_rs, t.drs);
        e.dbdepen     = ref_sel(t, t.duse_rt, t.drt);
        e.dsdepen     = ref_sel(t, t.duse_st, t.drt);
        e.redirect    = bt;
        e.redirect_pc = bt ? t.ebpc : 32'h0;
        e.fflush      = bt;
        e.dbubble     = bt | lu;
        e.wpcir       = bt | !lu;
        e.stall_cnt   = m_stall;
        e.flush_cnt   = m_flush;
        e.stall_s     = m_stall_s;
        e.flush_s     = m_flush_s;
        return e;
    endfunction

    task automatic model_advance(input txn_t t, input logic c);
        if (c) begin
            m_stall = '0; m_flush = '0; m_stall_s = '0; m_flush_s = '0;
        end else if (ref_bt(t)) begin
            if (m_flush != 16'hFFFF) m_flush++;
            if (m_flush_s != 2'b11) m_flush_s++;
        end else if (ref_lu(t)) begin
            if (m_stall != 16'hFFFF) m_stall++;
            if (m_stall_s != 2'b11) m_stall_s++;
        end
    endtask

    // Drive one cycle's inputs just after the edge; the preceding cycle's
    // inputs have just been clocked, so advance the model first.
    txn_t prev_t;
    logic prev_clr;
    task automatic step(input txn_t t, input logic c, input logic do_chk);
        @(posedge clk);
        model_advance(prev_t, prev_clr);
        #1;
        t_in = t;
        clr  = c;
        prev_t = t;
        prev_clr = c;
        if (do_chk) exp_q.push_back(ref_out(t));
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            $display("txn t=%0t clr=%0b a=%0d b=%0d s=%0d wpcir=%0b bub=%0b fl=%0b rd=%0b pc=%0h sc=%0d fc=%0d",
                     $time, clr, dadepen, dbdepen, dsdepen, wpcir, dbubble, fflush,
                     redirect, redirect_pc, stall_cnt, flush_cnt);
            check_val("dadepen", {30'd0, dadepen}, {30'd0, e.dadepen});
            check_val("dbdepen", {30'd0, dbdepen}, {30'd0, e.dbdepen});
            check_val("dsdepen", {30'd0, dsdepen}, {30'd0, e.dsdepen});
            check_val("wpcir", {31'd0, wpcir}, {31'd0, e.wpcir});
            check_val("dbubble", {31'd0, dbubble}, {31'd0, e.dbubble});
            check_val("fflush", {31'd0, fflush}, {31'd0, e.fflush});
            check_val("redirect", {31'd0, redirect}, {31'd0, e.redirect});
            check_val("redirect_pc", redirect_pc, e.redirect_pc);
            check_val("stall_cnt", {16'd0, stall_cnt}, {16'd0, e.stall_cnt});
            check_val("flush_cnt", {16'd0, flush_cnt}, {16'd0, e.flush_cnt});
            check_val("stall_cnt_w2", {30'd0, stall_cnt_s}, {30'd0, e.stall_s});
            check_val("flush_cnt_w2", {30'd0, flush_cnt_s}, {30'd0, e.flush_s});
            check_val("w2_wpcir", {31'd0, wpcir_s}, {31'd0, e.wpcir});
            check_val("w2_redirect_pc", redirect_pc_s, e.redirect_pc);
        end
    end

    initial begin
        txn_t t;
        m_stall = '0; m_flush = '0; m_stall_s = '0; m_flush_s = '0;
        prev_t = '0; prev_clr = 1'b1;
        t_in = '0; clr = 1'b1;
        t = '0;
        step(t, 1'b1, 1'b0);            // counters unknown before the first edge
        step(t, 1'b1, 1'b1);

        // 1: forward from execute
        t = '0; t.ewreg = 1; t.ern = 5; t.drs = 5; t.duse_rs = 1;
        step(t, 1'b0, 1'b1);
        // 2: load-use, then load in memory stage
        t = '0; t.ewreg = 1; t.em2reg = 1; t.ern = 8; t.drt = 8; t.duse_rt = 1;
        step(t, 1'b0, 1'b1);
        t = '0; t.mwreg = 1; t.mm2reg = 1; t.mrn = 8; t.drt = 8; t.duse_rt = 1;
        step(t, 1'b0, 1'b1);
        // 3: taken beq with load-use present, then squash cycle
        t = '0; t.ebeq = 1; t.ezero = 1; t.ebpc = 32'h40;
        t.ewreg = 1; t.em2reg = 1; t.ern = 8; t.drt = 8; t.duse_rt = 1;
        step(t, 1'b0, 1'b1);
        t = '0; t.drs = 2; t.duse_rs = 1;
        step(t, 1'b0, 1'b1);
        // 4: untaken bne, then jump
        t = '0; t.ebne = 1; t.ezero = 1; t.ebpc = 32'h80;
        step(t, 1'b0, 1'b1);
        t = '0; t.ej = 1; t.ebpc = 32'h100;
        step(t, 1'b0, 1'b1);
        // 5: register 0 never stalls; execute beats memory
        t = '0; t.ewreg = 1; t.em2reg = 1; t.ern = 0; t.drs = 0; t.duse_rs = 1;
        step(t, 1'b0, 1'b1);
        t = '0; t.ewreg = 1; t.ern = 3; t.mwreg = 1; t.mrn = 3; t.drs = 3; t.duse_rs = 1;
        step(t, 1'b0, 1'b1);
        // store-data forwarding from memory ALU
        t = '0; t.mwreg = 1; t.mrn = 9; t.drt = 9; t.duse_st = 1;
        step(t, 1'b0, 1'b1);
        // 6: four load-use events saturate the 2-bit counter, then reset in LSTALL
        t = '0; t.ewreg = 1; t.em2reg = 1; t.ern = 4; t.drs = 4; t.duse_rs = 1;
        for (int i = 0; i < 4; i++) step(t, 1'b0, 1'b1);
        step(t, 1'b0, 1'b1);
        t = '0;
        step(t, 1'b1, 1'b1);
        step(t, 1'b0, 1'b1);

        // Random traffic over a small register range to hit matches often
        for (int i = 0; i < 250; i++) begin
            t.drs = 5'($urandom_range(0, 3));
            t.drt = 5'($urandom_range(0, 3));
            t.ern = 5'($urandom_range(0, 3));
            t.mrn = 5'($urandom_range(0, 3));
            t.duse_rs = 1'($urandom); t.duse_rt = 1'($urandom); t.duse_st = 1'($urandom);
            t.ewreg = 1'($urandom); t.em2reg = 1'($urandom);
            t.mwreg = 1'($urandom); t.mm2reg = 1'($urandom);
            t.ej = ($urandom_range(0, 7) == 0);
            t.ebeq = ($urandom_range(0, 5) == 0);
            t.ebne = ($urandom_range(0, 5) == 0);
            t.ezero = 1'($urandom);
            t.ebpc = $urandom;
            step(t, ($urandom_range(0, 40) == 0), 1'b1);
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        check_val("drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
